// File: rtl/popcount_stream_ctrl_pkg.sv
// Shared constants, state encoding and pipeline bundle
// for the packet popcount sequencer.
package popcount_ctrl_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int PC_WIDTH   = 6;

    localparam logic [1:0] S_ACC   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    typedef struct packed {
        logic                vld;
        logic                last;
        logic [PC_WIDTH-1:0] pc;
    } pc_stage_t;

endpackage

// File: rtl/popcount_stream_ctrl_if.sv
// Beat-in / result-out handshake bundle for
// popcount_stream_ctrl.
interface popcount_stream_ctrl_if #(
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 10
);
    import popcount_ctrl_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_count;
    logic [BEAT_WIDTH-1:0] out_beats;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid,
        input  out_count, out_beats, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid,
        output out_count, out_beats, out_sat
    );

endinterface

// File: rtl/popcount_stream_ctrl_popcount.sv
// Combinational set-bit counter for one 32-bit word.
module popcount_int32
    import popcount_ctrl_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] word,
    output logic [PC_WIDTH-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            count = count + PC_WIDTH'(word[i]);
        end
    end

endmodule

// File: rtl/popcount_stream_ctrl.sv
// Streams words through one popcount, accumulates a
// saturating per-packet bit/beat total, hands it out.
module popcount_stream_ctrl
    import popcount_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    popcount_stream_ctrl_if.slave bus
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    pc_stage_t             pc_q;
    logic                  done_q;
    logic [PC_WIDTH-1:0]   pc_word;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [BEAT_WIDTH-1:0] beats_q;
    logic                  sat_q;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [BEAT_WIDTH:0]   beats_sum;
    logic [ACC_WIDTH-1:0]  acc_nxt;
    logic [BEAT_WIDTH-1:0] beats_nxt;
    logic                  in_fire;
    logic                  out_fire;

    popcount_int32 u_pc (
        .word  (bus.in_data),
        .count (pc_word)
    );

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_count = acc_q;
    assign bus.out_beats = beats_q;
    assign bus.out_sat   = sat_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // Carry-out of the widened add marks saturation.
    assign acc_sum   = {1'b0, acc_q}
                     + (ACC_WIDTH+1)'(pc_q.pc);
    assign beats_sum = {1'b0, beats_q}
                     + (BEAT_WIDTH+1)'(1);
    assign acc_nxt   = acc_sum[ACC_WIDTH]
                     ? '1 : acc_sum[ACC_WIDTH-1:0];
    assign beats_nxt = beats_sum[BEAT_WIDTH]
                     ? '1 : beats_sum[BEAT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == S_ACC):
                if (in_fire && bus.in_last) state_d = S_FLUSH;
            (state_q == S_FLUSH):
                if (done_q) state_d = S_OUT;
            (state_q == S_OUT):
                if (out_fire) state_d = S_ACC;
            default:
                state_d = S_ACC;
        endcase
    end

    // done_q rises once the last beat has landed in acc_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            pc_q    <= '0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            beats_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q.vld <= in_fire;
            if (in_fire) begin
                pc_q.pc   <= pc_word;
                pc_q.last <= bus.in_last;
            end
            done_q <= pc_q.vld & pc_q.last;
            if (out_fire) begin
                acc_q   <= '0;
                beats_q <= '0;
                sat_q   <= 1'b0;
            end else if (pc_q.vld) begin
                acc_q   <= acc_nxt;
                beats_q <= beats_nxt;
                sat_q   <= sat_q | acc_sum[ACC_WIDTH]
                         | beats_sum[BEAT_WIDTH];
            end
        end
    end

endmodule
